// File: rtl/syn_io_pkg.sv
// Shared types and widths for the synapse I/O client.
package syn_io_pkg;

  localparam int SYN_DATA_W = 128;
  localparam int SYN_PAT_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    COLLECT,
    RESP
  } syn_state_e;

  typedef struct packed {
    logic [2*SYN_DATA_W-1:0] data;
    logic [SYN_PAT_W-1:0]    pat_ctr;
    logic                    err;
  } syn_rsp_t;

endpackage

// File: rtl/syn_io_client_beat_buf.sv
// Two-channel result capture buffer with per-channel arrival and duplicate tracking.
module syn_io_beat_buf
  import syn_io_pkg::*;
#(
  parameter int DATA_W = SYN_DATA_W,
  parameter int PAT_W  = SYN_PAT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                capture,
  input  logic                channel,
  input  logic [DATA_W-1:0]   data,
  input  logic [PAT_W-1:0]    pat_ctr,
  output logic [2*DATA_W-1:0] buf_data,
  output logic [PAT_W-1:0]    buf_pat_ctr,
  output logic                got0,
  output logic                got1,
  output logic                dup_err
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_data    <= '0;
      buf_pat_ctr <= '0;
      got0        <= 1'b0;
      got1        <= 1'b0;
      dup_err     <= 1'b0;
    end else if (clear) begin
      buf_data    <= '0;
      buf_pat_ctr <= '0;
      got0        <= 1'b0;
      got1        <= 1'b0;
      dup_err     <= 1'b0;
    end else if (capture) begin
      // A repeated channel still overwrites its half; the error is sticky.
      if (channel) begin
        buf_data[2*DATA_W-1:DATA_W] <= data;
        got1                        <= 1'b1;
        if (got1) dup_err <= 1'b1;
      end else begin
        buf_data[DATA_W-1:0] <= data;
        got0                 <= 1'b1;
        if (got0) dup_err <= 1'b1;
      end
      buf_pat_ctr <= pat_ctr;
    end
  end

endmodule

// File: rtl/syn_io_client.sv
// Client controller for the synapse I/O port: start, collect two beats, respond.
// Optional watchdog on WAIT_BUSY/COLLECT enabled by SYN_IO_CLIENT_TIMEOUT_EN.
module syn_io_client
  import syn_io_pkg::*;
#(
  parameter int DATA_W      = SYN_DATA_W,
  parameter int PAT_W       = SYN_PAT_W,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  output logic                syn_start,
  input  logic                syn_busy,
  input  logic                syn2client_valid,
  input  logic                syn2client_channel,
  input  logic [DATA_W-1:0]   syn2client_data,
  input  logic [PAT_W-1:0]    syn2client_pat_ctr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [2*DATA_W-1:0] rsp_data,
  output logic [PAT_W-1:0]    rsp_pat_ctr,
  output logic                rsp_err
);

  syn_state_e state, state_n;
  logic       cmd_ready_n, syn_start_n, rsp_valid_n, rsp_err_n;
  logic       buf_clear, beat_en;
  logic       got0, got1, dup_err;

  assign beat_en = syn2client_valid && ((state == WAIT_BUSY) || (state == COLLECT));

  syn_io_beat_buf #(
    .DATA_W (DATA_W),
    .PAT_W  (PAT_W)
  ) u_beat_buf (
    .clk         (clk),
    .reset       (reset),
    .clear       (buf_clear),
    .capture     (beat_en),
    .channel     (syn2client_channel),
    .data        (syn2client_data),
    .pat_ctr     (syn2client_pat_ctr),
    .buf_data    (rsp_data),
    .buf_pat_ctr (rsp_pat_ctr),
    .got0        (got0),
    .got1        (got1),
    .dup_err     (dup_err)
  );

`ifdef SYN_IO_CLIENT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt;
  logic          timeout_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt <= '0;
    end else if (state == START) begin
      tcnt <= '0;
    end else if ((state == WAIT_BUSY) || (state == COLLECT)) begin
      tcnt <= tcnt + 1'b1;
    end
  end

  // Decided one count early so the registered rsp_valid lands as the count reaches TIMEOUT_CYC.
  assign timeout_hit = ((state == WAIT_BUSY) || (state == COLLECT)) &&
                       (tcnt == TW'(TIMEOUT_CYC - 1));
`endif

  always_comb begin
    state_n   = state;
    rsp_err_n = rsp_err;
    buf_clear = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_n   = START;
          buf_clear = 1'b1;
          rsp_err_n = 1'b0;
        end
      end
      START:     state_n = WAIT_BUSY;
      WAIT_BUSY: if (syn_busy || syn2client_valid) state_n = COLLECT;
      COLLECT: begin
        if (!syn_busy && !syn2client_valid) begin
          state_n   = RESP;
          rsp_err_n = dup_err | ~got0 | ~got1;
        end
      end
      RESP:      if (rsp_valid && rsp_ready) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
`ifdef SYN_IO_CLIENT_TIMEOUT_EN
    if (timeout_hit) begin
      state_n   = RESP;
      rsp_err_n = 1'b1;
    end
`endif
    // Outputs are registered from the next state, so they track the state register exactly.
    cmd_ready_n = (state_n == IDLE);
    syn_start_n = (state_n == START);
    rsp_valid_n = (state_n == RESP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      syn_start <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_n;
      cmd_ready <= cmd_ready_n;
      syn_start <= syn_start_n;
      rsp_valid <= rsp_valid_n;
      rsp_err   <= rsp_err_n;
    end
  end

endmodule

// File: tb/tb_syn_io_client.sv
// Self-checking bench for syn_io_client with a transaction-level response model.
module tb_syn_io_client;
  import syn_io_pkg::*;

  localparam int DW = 128;
  localparam int PW = 8;

  typedef struct {
    bit            ch;
    logic [DW-1:0] d;
    logic [PW-1:0] p;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, syn_start, syn_busy;
  logic          syn2client_valid, syn2client_channel;
  logic [DW-1:0] syn2client_data;
  logic [PW-1:0] syn2client_pat_ctr;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [2*DW-1:0] rsp_data;
  logic [PW-1:0] rsp_pat_ctr;

  int n_assert = 0;
  int n_fail   = 0;
  beat_t bq[$];

  always #5 clk = ~clk;

  syn_io_client #(
    .DATA_W      (DW),
    .PAT_W       (PW),
    .TIMEOUT_CYC (64)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .syn_start          (syn_start),
    .syn_busy           (syn_busy),
    .syn2client_valid   (syn2client_valid),
    .syn2client_channel (syn2client_channel),
    .syn2client_data    (syn2client_data),
    .syn2client_pat_ctr (syn2client_pat_ctr),
    .rsp_valid          (rsp_valid),
    .rsp_ready          (rsp_ready),
    .rsp_data           (rsp_data),
    .rsp_pat_ctr        (rsp_pat_ctr),
    .rsp_err            (rsp_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic push(input bit ch, input logic [DW-1:0] d, input logic [PW-1:0] p);
    beat_t b;
    b.ch = ch; b.d = d; b.p = p;
    bq.push_back(b);
  endtask

  task automatic accept_cmd();
    int waited = 0;
    while (!cmd_ready && waited < 20) begin
      tick();
      waited++;
    end
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("syn_start_pulse", syn_start, 1);
    chk("cmd_ready_low_active", cmd_ready, 0);
    tick();
    chk("syn_start_one_cycle", syn_start, 0);
  endtask

  task automatic handshake();
    cmd_valid = 1'b0;
    syn2client_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_valid_cleared", rsp_valid, 0);
    chk("cmd_ready_after_hs", cmd_ready, 1);
  endtask

  // Expected response: each channel must arrive exactly once; last beat wins data and pat_ctr.
  task automatic run_txn(input int hold);
    syn_rsp_t e;
    int c0 = 0;
    int c1 = 0;
    e = '0;
    foreach (bq[i]) begin
      if (bq[i].ch) begin e.data[2*DW-1:DW] = bq[i].d; c1++; end
      else begin e.data[DW-1:0] = bq[i].d; c0++; end
      e.pat_ctr = bq[i].p;
    end
    e.err = (c0 != 1) || (c1 != 1);

    accept_cmd();
    syn_busy = 1'b1;
    repeat (10) tick();
    foreach (bq[i]) begin
      repeat ($urandom_range(0, 2)) tick();
      syn2client_valid   = 1'b1;
      syn2client_channel = bq[i].ch;
      syn2client_data    = bq[i].d;
      syn2client_pat_ctr = bq[i].p;
      if (i == bq.size() - 1) syn_busy = 1'b0;
      tick();
      syn2client_valid = 1'b0;
      syn2client_data  = rnd128();
    end
    chk("rsp_valid_not_yet", rsp_valid, 0);
    tick();
    chk("rsp_valid_latency", rsp_valid, 1);
    chk("rsp_data", rsp_data, e.data);
    chk("rsp_pat_ctr", rsp_pat_ctr, e.pat_ctr);
    chk("rsp_err", rsp_err, e.err);

    cmd_valid = 1'b1;
    for (int k = 0; k < hold; k++) begin
      syn2client_valid   = $urandom_range(0, 1);
      syn2client_channel = $urandom_range(0, 1);
      syn2client_data    = rnd128();
      syn2client_pat_ctr = PW'($urandom);
      tick();
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_data", rsp_data, e.data);
      chk("bp_rsp_pat", rsp_pat_ctr, e.pat_ctr);
      chk("bp_rsp_err", rsp_err, e.err);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_no_start", syn_start, 0);
    end
    handshake();
    bq.delete();
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0; syn_busy = 1'b0; rsp_ready = 1'b0;
    syn2client_valid = 1'b0; syn2client_channel = 1'b0;
    syn2client_data = '0; syn2client_pat_ctr = '0;
    tick(); tick();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_syn_start", syn_start, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_pat", rsp_pat_ctr, 0);
    chk("rst_rsp_err", rsp_err, 0);
    reset = 1'b0;
    tick();
    chk("cmd_ready_after_rst", cmd_ready, 1);

    // Nominal two-beat read
    push(1'b0, {4{32'haffe_affe}}, 8'h12);
    push(1'b1, {4{32'habcd_0123}}, 8'h34);
    run_txn(0);

    // Backpressure with stray command and beats
    push(1'b0, rnd128(), 8'h55);
    push(1'b1, rnd128(), 8'h66);
    run_txn(5);

    // Missing channel 1
    push(1'b0, {4{32'haffe_affe}}, 8'h01);
    run_txn(1);

    // Duplicate channel 0
    push(1'b0, {4{32'haffe_affe}}, 8'h02);
    push(1'b0, {4{32'h1111_1111}}, 8'h03);
    push(1'b1, {4{32'habcd_0123}}, 8'h04);
    run_txn(0);

    // Randomised beat sets
    for (int t = 0; t < 8; t++) begin
      int nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) push(1'($urandom_range(0, 1)), rnd128(), PW'($urandom));
      run_txn($urandom_range(0, 3));
    end

    // Reset during COLLECT after one beat
    accept_cmd();
    syn_busy = 1'b1;
    repeat (3) tick();
    begin
      logic [DW-1:0] d0;
      d0 = rnd128();
      syn2client_valid = 1'b1; syn2client_channel = 1'b0;
      syn2client_data = d0; syn2client_pat_ctr = 8'h77;
      tick();
      syn2client_valid = 1'b0;
      chk("mid_capture", rsp_data, {128'h0, d0});
    end
    #2 reset = 1'b1;
    #1;
    chk("async_rst_data", rsp_data, 0);
    chk("async_rst_pat", rsp_pat_ctr, 0);
    chk("async_rst_cmd_ready", cmd_ready, 0);
    chk("async_rst_rsp_valid", rsp_valid, 0);
    chk("async_rst_rsp_err", rsp_err, 0);
    chk("async_rst_start", syn_start, 0);
    syn_busy = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rel_cmd_ready", cmd_ready, 1);
    begin
      int seen = 0;
      repeat (5) begin
        tick();
        if (rsp_valid) seen = 1;
      end
      chk("no_rsp_after_rst", seen, 0);
    end

    // Busy held with no beats
    accept_cmd();
    syn_busy = 1'b1;
`ifdef SYN_IO_CLIENT_TIMEOUT_EN
    begin
      int k = 0;
      while (!rsp_valid && k < 200) begin
        tick();
        k++;
      end
      chk("timeout_cycles", k, 64);
    end
`else
    begin
      int seen = 0;
      repeat (100) begin
        tick();
        if (rsp_valid) seen = 1;
      end
      chk("busy_never_completes", seen, 0);
    end
    syn_busy = 1'b0;
    tick();
    chk("busy_drop_rsp_valid", rsp_valid, 1);
`endif
    chk("busy_only_err", rsp_err, 1);
    chk("busy_only_data", rsp_data, 0);
    syn_busy = 1'b0;
    handshake();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/syn_io_client.md
Name: syn_io_client

Overview:
- Client-side controller for the synapse I/O port. It sits between the processor's command path and the synapse I/O stage that consumes start and produces syn2client beats.
- Accepts one read command at a time, pulses start, and waits for the synapse stage to go busy.
- Captures the two 128-bit result beats (channel 0, channel 1) into a 256-bit buffer, then returns them to the processor with a valid/ready handshake and status flags.

Parameters:
- DATA_W, 128, width of one syn2client beat.
- PAT_W, 8, width of the pattern counter field.
- TIMEOUT_CYC, 64, cycles allowed in WAIT_BUSY or COLLECT before abort (only with the optional feature).

Ports:
- clk  in  1  clock
- reset  in  1  reset
- cmd_valid  in  1  processor requests a synapse read
- cmd_ready  out  1  block can accept a command (high only in IDLE)
- syn_start  out  1  start pulse to the synapse stage
- syn_busy  in  1  synapse stage busy
- syn2client_valid  in  1  result beat valid
- syn2client_channel  in  1  beat channel, 0 = low half, 1 = high half
- syn2client_data  in  DATA_W  beat payload
- syn2client_pat_ctr  in  PAT_W  pattern counter from the synapse stage
- rsp_valid  out  1  response available
- rsp_ready  in  1  processor accepts response
- rsp_data  out  2*DATA_W  {ch1 beat, ch0 beat}
- rsp_pat_ctr  out  PAT_W  pat_ctr sampled with the last valid beat
- rsp_err  out  1  protocol error or timeout

Behaviour:
- Reset (asynchronous, active-high) forces the state to IDLE and sets all outputs to 0: cmd_ready, syn_start, rsp_valid, rsp_data, rsp_pat_ctr, rsp_err. cmd_ready rises in the first cycle after reset deasserts. Reset mid-transaction discards the transaction with no response.
- All outputs are registered.
- States:
  - IDLE: cmd_ready = 1. On cmd_valid && cmd_ready, go to START; clear the buffer, got0, got1 and err.
  - START: syn_start = 1 for exactly one cycle, then go to WAIT_BUSY.
  - WAIT_BUSY: go to COLLECT when syn_busy == 1, or when syn2client_valid == 1 (that beat is captured).
  - COLLECT: every cycle with syn2client_valid == 1:
    - channel 0 writes rsp_data[DATA_W-1:0] and sets got0; channel 1 writes the upper half and sets got1.
    - rsp_pat_ctr is loaded from syn2client_pat_ctr.
    - A beat for a channel already received overwrites the data and sets err.
    - When syn_busy == 0 and syn2client_valid == 0, go to RESP with rsp_err = err | !got0 | !got1.
  - RESP: rsp_valid = 1. rsp_data, rsp_pat_ctr and rsp_err are held stable until rsp_valid && rsp_ready, then go to IDLE. cmd_ready rises in the cycle after the handshake.
- Simultaneous busy fall and valid beat: the beat is captured and completion is deferred one cycle.
- Beats arriving in IDLE or RESP are ignored and do not change the outputs.
- cmd_valid is ignored outside IDLE.
- Latency with a synapse stage that answers after 10 cycles: command accept → syn_start is 1 cycle; last beat → rsp_valid is 2 cycles.
- syn_busy staying 1 without beats never completes unless the timeout feature is compiled in.

Optional Feature:
- Macro: SYN_IO_CLIENT_TIMEOUT_EN.
- Defined:
  - A counter of $clog2(TIMEOUT_CYC+1) bits is cleared on entry to WAIT_BUSY and increments in WAIT_BUSY and COLLECT.
  - Reaching TIMEOUT_CYC moves to RESP with rsp_err = 1; partially captured data is returned as is.
- Undefined: no counter logic; the block waits indefinitely.

Decomposition:
- Package syn_io_pkg holds:
  - the state enum typedef (IDLE, START, WAIT_BUSY, COLLECT, RESP);
  - localparams SYN_DATA_W = 128 and SYN_PAT_W = 8;
  - a packed struct syn_rsp_t {data, pat_ctr, err}.
- Sub-module syn_io_beat_buf is natural: the 2×DATA_W capture buffer with the got0/got1/dup-error tracking, cleared by the FSM.

Test Plan:
- Nominal: cmd_valid 1 cycle against a model that asserts busy next cycle, then after 10 cycles sends beats ch0 = {4{32'haffe_affe}} and ch1 = {4{32'habcd_0123}} → syn_start 1 cycle; rsp_data = {ch1, ch0}; rsp_err = 0; rsp_valid 2 cycles after the last beat.
- Backpressure: hold rsp_ready = 0 for 5 cycles → rsp_valid stays high, rsp_data stable, cmd_ready = 0 and a new cmd_valid is ignored. rsp_ready = 1 → IDLE next cycle.
- Missing beat: model sends only ch0, then drops busy → rsp_err = 1, lower half correct, upper half 0.
- Duplicate: model sends ch0, ch0 = 32'h1111_1111 replicated, then ch1 → rsp_err = 1, lower half = 128'h1111…1111.
- Reset mid-COLLECT after the first beat → all outputs 0 immediately, cmd_ready = 1 after release, no rsp_valid.
- With SYN_IO_CLIENT_TIMEOUT_EN and TIMEOUT_CYC = 64: model holds busy = 1 forever → rsp_valid with rsp_err = 1 exactly 64 cycles after entering WAIT_BUSY.
